cw_keyer_envelope: RTL and testbench

// - Downstream stage of the callsign Morse generator. Turns the raw on/off Morse bit into a shaped keying envelope plus PTT sequencing for the TX DAC/modulator.
// - Linear amplitude ramps suppress key clicks. PTT lead/tail hang time keeps the PA keyed across characters.
// - Runs on the system clock. Timing advances only on DAC sample strobes.

---
 rtl/cw_keyer_envelope.sv | 222 ++++++++++++++++++++++
 tb/tb_cw_keyer_envelope.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cw_keyer_envelope.sv
// cw_keyer_envelope: shapes the raw Morse bit into a linear-ramp keying envelope with PTT lead/tail sequencing.
// Optional stuck-key watchdog enabled by defining CW_KEY_TIMEOUT_EN.
`default_nettype none

module cw_keyer_envelope #(
    parameter int AMP_W      = 12,
    parameter int AMP_MAX    = 4095,
    parameter int RAMP_STEPS = 64,
    parameter int PTT_LEAD   = 256,
    parameter int PTT_TAIL   = 2048,
    parameter int TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_in,
    input  logic             sample_en,
    input  logic             tx_enable,
    output logic             ptt,
    output logic [AMP_W-1:0] amp,
    output logic             amp_valid,
    output logic             fault
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEAD = 3'd1;
    localparam logic [2:0] S_RISE = 3'd2;
    localparam logic [2:0] S_HOLD = 3'd3;
    localparam logic [2:0] S_FALL = 3'd4;
    localparam logic [2:0] S_TAIL = 3'd5;

    localparam int R_W    = $clog2(RAMP_STEPS + 1);
    localparam int CNT_M1 = (PTT_LEAD > PTT_TAIL) ? PTT_LEAD : PTT_TAIL;
    localparam int CNT_MV = (CNT_M1 > TIMEOUT) ? CNT_M1 : TIMEOUT;
    localparam int CNT_W  = $clog2(CNT_MV + 2);

    localparam logic [R_W-1:0]   R_TOP     = R_W'(RAMP_STEPS);
    localparam logic [R_W-1:0]   R_PRE     = R_W'(RAMP_STEPS - 1);
    localparam logic [R_W-1:0]   R_ONE     = R_W'(1);
    localparam logic [AMP_W-1:0] AMP_FULL  = AMP_W'(AMP_MAX);
    localparam logic [AMP_W-1:0] STEP      = AMP_W'(AMP_MAX / RAMP_STEPS);
    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'((PTT_LEAD == 0) ? 0 : PTT_LEAD - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'((PTT_TAIL == 0) ? 0 : PTT_TAIL - 1);
`ifdef CW_KEY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
`endif

    logic             key_meta;
    logic             key_s;
    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [R_W-1:0]   r;
    logic [R_W-1:0]   r_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] cnt_inc;
    logic             abort;
    logic             abort_nx;
    logic             go_up;
    logic             go_down;
    logic             key_on;
    logic [AMP_W-1:0] amp_nx;
`ifdef CW_KEY_TIMEOUT_EN
    logic             fault_q;
    logic             fault_nx;
    logic             timeout_hit;
`endif

    assign key_on  = key_s & tx_enable;
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

    // abort marks a ramp-down that must end in IDLE (tx disabled or watchdog) and ignores the key
    always_comb begin
        state_nx = state;
        r_nx     = r;
        cnt_nx   = cnt_inc;
        abort_nx = abort;
        go_up    = 1'b0;
        go_down  = 1'b0;
`ifdef CW_KEY_TIMEOUT_EN
        fault_nx    = fault_q;
        timeout_hit = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                r_nx     = '0;
                cnt_nx   = '0;
                abort_nx = 1'b0;
`ifdef CW_KEY_TIMEOUT_EN
                if (fault_q) begin
                    if (!key_s) fault_nx = 1'b0;
                end else if (key_on) begin
                    state_nx = S_LEAD;
                end
`else
                if (key_on) state_nx = S_LEAD;
`endif
            end
            S_LEAD: begin
                if (!tx_enable) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (cnt >= LEAD_LAST) begin
                    if (key_on) begin
                        go_up = 1'b1;
                    end else begin
                        state_nx = S_TAIL;
                        cnt_nx   = '0;
                    end
                end
            end
            S_RISE: begin
                if (key_on) begin
                    go_up = 1'b1;
                end else begin
                    go_down  = 1'b1;
                    abort_nx = !tx_enable;
                end
            end
            S_HOLD: begin
`ifdef CW_KEY_TIMEOUT_EN
                timeout_hit = key_on && (cnt >= TO_LAST);
                if (!key_on || timeout_hit) begin
                    go_down  = 1'b1;
                    abort_nx = !tx_enable || timeout_hit;
                    fault_nx = timeout_hit;
                end
`else
                cnt_nx = cnt;
                if (!key_on) begin
                    go_down  = 1'b1;
                    abort_nx = !tx_enable;
                end
`endif
            end
            S_FALL: begin
                if (key_on && !abort) begin
                    go_up = 1'b1;
                end else begin
                    go_down  = 1'b1;
                    abort_nx = abort | !tx_enable;
                end
            end
            S_TAIL: begin
                if (!tx_enable) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (key_on) begin
                    go_up = 1'b1;
                end else if (cnt >= TAIL_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                r_nx     = '0;
                cnt_nx   = '0;
                abort_nx = 1'b0;
            end
        endcase

        if (go_up) begin
            r_nx     = (r >= R_TOP) ? R_TOP : r + 1'b1;
            state_nx = (r >= R_PRE) ? S_HOLD : S_RISE;
            cnt_nx   = '0;
        end
        if (go_down) begin
            r_nx = (r == '0) ? '0 : r - 1'b1;
            if (r <= R_ONE) begin
                state_nx = abort_nx ? S_IDLE : S_TAIL;
                cnt_nx   = '0;
            end else begin
                state_nx = S_FALL;
            end
        end
    end

    assign amp_nx = (r_nx == R_TOP) ? AMP_FULL : AMP_W'(r_nx) * STEP;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta  <= 1'b0;
            key_s     <= 1'b0;
            state     <= S_IDLE;
            r         <= '0;
            cnt       <= '0;
            abort     <= 1'b0;
            ptt       <= 1'b0;
            amp       <= '0;
            amp_valid <= 1'b0;
        end else begin
            key_meta  <= key_in;
            key_s     <= key_meta;
            amp_valid <= sample_en;
            if (sample_en) begin
                state <= state_nx;
                r     <= r_nx;
                cnt   <= cnt_nx;
                abort <= abort_nx;
                ptt   <= (state_nx != S_IDLE);
                amp   <= amp_nx;
            end
        end
    end

`ifdef CW_KEY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (sample_en) begin
            fault_q <= fault_nx;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cw_keyer_envelope.sv
// tb_cw_keyer_envelope: directed checks of envelope ramps, PTT lead/tail, reversal and tx_enable abort.
`default_nettype none

module tb_cw_keyer_envelope;

    logic        clk;
    logic        rst_n;
    logic        key_in;
    logic        sample_en;
    logic        tx_enable;
    logic        ptt;
    logic [11:0] amp;
    logic        amp_valid;
    logic        fault;

    int errors = 0;
    int checks = 0;
    logic [1:0] phase = 2'd0;

    cw_keyer_envelope #(
        .AMP_W(12), .AMP_MAX(4095), .RAMP_STEPS(4),
        .PTT_LEAD(3), .PTT_TAIL(5), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .sample_en(sample_en),
        .tx_enable(tx_enable), .ptt(ptt), .amp(amp), .amp_valid(amp_valid), .fault(fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // sample strobe once every 4 clocks, changed on the falling edge
    always @(negedge clk) begin
        phase     = phase + 2'd1;
        sample_en = (phase == 2'd0);
    end

    task automatic sample();
        int guard;
        guard = 0;
        @(posedge clk);
        while (!sample_en && guard < 16) begin
            @(posedge clk);
            guard++;
        end
        #1;
    endtask

    task automatic go_idle();
        key_in    = 1'b0;
        tx_enable = 1'b1;
        repeat (12) sample();
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ptt !== 1'b0) begin errors++; $display("FAIL reset_ptt got %b want 0", ptt); end
        checks++; if (amp !== 12'd0) begin errors++; $display("FAIL reset_amp got %0d want 0", amp); end
        checks++; if (amp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", amp_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) sample();
    endtask

    task automatic test_single_dit();
        int exp_amp [19] = '{0, 0, 0, 1023, 2046, 3069, 4095, 4095, 4095, 4095,
                             3069, 2046, 1023, 0, 0, 0, 0, 0, 0};
        tx_enable = 1'b1;
        sample();
        key_in = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            sample();
            checks++;
            if (ptt !== (i < 19)) begin errors++; $display("FAIL dit_ptt[%0d] got %b want %b", i, ptt, (i < 19)); end
            checks++;
            if (amp !== 12'(exp_amp[i-1])) begin errors++; $display("FAIL dit_amp[%0d] got %0d want %0d", i, amp, exp_amp[i-1]); end
            if (i == 1) begin
                checks++;
                if (amp_valid !== 1'b1) begin errors++; $display("FAIL dit_valid_hi got %b want 1", amp_valid); end
            end
            if (i == 10) key_in = 1'b0;
        end
        @(posedge clk); #1;
        checks++; if (amp_valid !== 1'b0) begin errors++; $display("FAIL dit_valid_lo got %b want 0", amp_valid); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL dit_fault got %b want 0", fault); end
        go_idle();
    endtask

    task automatic test_reversal();
        int exp_amp [9] = '{0, 0, 0, 1023, 2046, 1023, 2046, 1023, 0};
        sample();
        key_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            sample();
            checks++;
            if (ptt !== 1'b1) begin errors++; $display("FAIL rev_ptt[%0d] got %b want 1", i, ptt); end
            checks++;
            if (amp !== 12'(exp_amp[i-1])) begin errors++; $display("FAIL rev_amp[%0d] got %0d want %0d", i, amp, exp_amp[i-1]); end
            if (i == 5) key_in = 1'b0;
            if (i == 6) key_in = 1'b1;
            if (i == 7) key_in = 1'b0;
        end
        go_idle();
    endtask

    task automatic test_tail_gap();
        int exp_amp [8] = '{0, 0, 0, 1023, 0, 0, 1023, 2046};
        sample();
        key_in = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            sample();
            checks++;
            if (ptt !== 1'b1) begin errors++; $display("FAIL gap_ptt[%0d] got %b want 1", i, ptt); end
            checks++;
            if (amp !== 12'(exp_amp[i-1])) begin errors++; $display("FAIL gap_amp[%0d] got %0d want %0d", i, amp, exp_amp[i-1]); end
            if (i == 4) key_in = 1'b0;
            if (i == 6) key_in = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_tx_disable();
        int exp_amp [14] = '{0, 0, 0, 1023, 2046, 3069, 4095, 4095, 3069, 2046, 1023, 0, 0, 0};
        sample();
        key_in = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            sample();
            checks++;
            if (ptt !== (i <= 11)) begin errors++; $display("FAIL txd_ptt[%0d] got %b want %b", i, ptt, (i <= 11)); end
            checks++;
            if (amp !== 12'(exp_amp[i-1])) begin errors++; $display("FAIL txd_amp[%0d] got %0d want %0d", i, amp, exp_amp[i-1]); end
            if (i == 8) tx_enable = 1'b0;
        end
        key_in = 1'b0;
        go_idle();
    endtask

    task automatic test_reset_mid_hold();
        sample();
        key_in = 1'b1;
        repeat (8) sample();
        checks++; if (amp !== 12'd4095) begin errors++; $display("FAIL rst_hold_amp got %0d want 4095", amp); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (ptt !== 1'b0) begin errors++; $display("FAIL rst_async_ptt got %b want 0", ptt); end
        checks++; if (amp !== 12'd0) begin errors++; $display("FAIL rst_async_amp got %0d want 0", amp); end
        checks++; if (amp_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %b want 0", amp_valid); end
        key_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) sample();
        checks++; if (ptt !== 1'b0) begin errors++; $display("FAIL rst_after_ptt got %b want 0", ptt); end
        checks++; if (amp !== 12'd0) begin errors++; $display("FAIL rst_after_amp got %0d want 0", amp); end
    endtask

`ifdef CW_KEY_TIMEOUT_EN
    task automatic test_timeout();
        int exp_amp [19] = '{0, 0, 0, 1023, 2046, 3069, 4095, 4095, 4095, 4095,
                             4095, 4095, 4095, 4095, 3069, 2046, 1023, 0, 0};
        sample();
        key_in = 1'b1;
        for (int i = 1; i <= 19; i++) begin
            sample();
            checks++;
            if (ptt !== (i <= 17)) begin errors++; $display("FAIL to_ptt[%0d] got %b want %b", i, ptt, (i <= 17)); end
            checks++;
            if (amp !== 12'(exp_amp[i-1])) begin errors++; $display("FAIL to_amp[%0d] got %0d want %0d", i, amp, exp_amp[i-1]); end
            if (i >= 18) begin
                checks++;
                if (fault !== 1'b1) begin errors++; $display("FAIL to_fault[%0d] got %b want 1", i, fault); end
            end
        end
        key_in = 1'b0;
        repeat (2) sample();
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", fault); end
        go_idle();
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        key_in    = 1'b0;
        tx_enable = 1'b0;
        sample_en = 1'b0;
        test_reset();
        test_single_dit();
        test_reversal();
        test_tail_gap();
        test_tx_disable();
`ifdef CW_KEY_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire
